// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_pkg : shared states, bit phases and bus-level decode for the I2C engine |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package i2c_pkg;

  localparam int FRAME_BYTES   = 3;
  localparam int BITS_PER_BYTE = 8;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t START   = 3'd1;
  localparam state_t BIT     = 3'd2;
  localparam state_t ACKSLOT = 3'd3;
  localparam state_t STOP    = 3'd4;
  localparam state_t DONE    = 3'd5;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  function automatic int qdiv(input int clk, input int i2c);
    return clk / (4 * i2c);
  endfunction

  // Returns {scl, sda_low} for a given state/phase; sda_low=1 pulls SDA to 0.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] ph,
                                            input logic bit_val);
    logic scl;
    logic sda_low;
    scl     = 1'b1;
    sda_low = 1'b0;
    case (st)
      START:   begin scl = (ph != P3); sda_low = (ph != P0); end
      BIT:     begin scl = ph[1];      sda_low = ~bit_val;   end
      ACKSLOT: begin scl = ph[1];      sda_low = 1'b0;       end
      STOP:    begin scl = ph[1];      sda_low = (ph != P3); end
      default: begin scl = 1'b1;       sda_low = 1'b0;       end
    endcase
    return {scl, sda_low};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_write_engine_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_tick_gen : quarter-bit tick divider, one tick every QDIV enabled cycles |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module i2c_tick_gen #(
  parameter int QDIV = 312
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = i_en && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_write_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_write_engine : I2C master that writes one 24-bit frame START/3x9/STOP   |
// | Optional macro I2C_NACK_ABORT_EN: go straight to STOP on the first NACK.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iGO,
  input  logic [23:0] iDATA,
  output logic        oBUSY,
  output logic        oEND,
  output logic        oACK,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int QDIV = qdiv(CLK_FREQ, I2C_FREQ);

  generate
    if (QDIV < 2) begin : g_qdiv_check
      $error("i2c_write_engine: QDIV must be >= 2");
    end
  endgenerate

`ifdef I2C_NACK_ABORT_EN
  localparam logic C_ABORT_ON_NACK = 1'b1;
`else
  localparam logic C_ABORT_ON_NACK = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        nack_q, nack_d;
  logic        ack_q, ack_d;
  logic        end_q, end_d;
  logic        scl_q, scl_d;
  logic        sda_low_q, sda_low_d;
  logic        sda_meta_q, sda_meta_d;
  logic        sda_sync_q, sda_sync_d;

  logic        accept;
  logic        tick;
  logic        tick_en;
  logic [1:0]  bus_d;

  // The oEND cycle still counts as busy, so a held iGO is only taken one cycle later.
  assign accept  = (state_q == IDLE) && !end_q && iGO;
  assign tick_en = (state_q != IDLE) && (state_q != DONE);

  i2c_tick_gen #(
    .QDIV (QDIV)
  ) u_tick (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .i_en   (tick_en),
    .i_clr  (accept),
    .o_tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    nack_d     = nack_q;
    ack_d      = ack_q;
    end_d      = 1'b0;
    if (accept) begin
      state_d    = START;
      phase_d    = P0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      shift_d    = iDATA;
      nack_d     = 1'b0;
      ack_d      = 1'b0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      end_d   = 1'b1;
      ack_d   = nack_q;
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
      if (phase_q == P3) begin
        case (state_q)
          START: state_d = BIT;
          BIT: begin
            shift_d = {shift_q[22:0], 1'b0};
            if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
              state_d = ACKSLOT;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          ACKSLOT: begin
            nack_d    = nack_q | sda_sync_q;
            bit_cnt_d = '0;
            if ((byte_cnt_q == 2'(FRAME_BYTES - 1)) || (C_ABORT_ON_NACK && sda_sync_q)) begin
              state_d = STOP;
            end else begin
              state_d    = BIT;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          STOP:    state_d = DONE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Bus pins are registered from the next state so they never glitch on decode.
  always_comb begin
    bus_d      = bus_levels(state_d, phase_d, shift_d[23]);
    scl_d      = bus_d[1];
    sda_low_d  = bus_d[0];
    sda_meta_d = I2C_SDAT;
    sda_sync_d = sda_meta_q;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      phase_q    <= P0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
      end_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
      end_q      <= end_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign oBUSY    = (state_q != IDLE) || end_q;
  assign oEND     = end_q;
  assign oACK     = ack_q;
  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_write_engine : directed + random frames against a bus-level slave    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_i2c_write_engine;

  localparam int CLK_FREQ = 80000;
  localparam int I2C_FREQ = 5000;
  localparam int Q        = CLK_FREQ / (4 * I2C_FREQ);

  logic        clk;
  logic        rst;
  logic        go;
  logic [23:0] data;
  logic        busy;
  logic        oend;
  logic        oack;
  logic        scl;
  wire         sda_w;
  logic        slave_low;

  int checks = 0;
  int errors = 0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  i2c_write_engine #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iGO      (go),
    .iDATA    (data),
    .oBUSY    (busy),
    .oEND     (oend),
    .oACK     (oack),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-level slave: decodes START/STOP/bits and answers ACK/NACK from nack_plan.
  logic [2:0] nack_plan = 3'b000;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic       in_frame  = 1'b0;
  int         bitpos    = 0;
  logic [7:0] shreg     = 8'h00;
  logic [7:0] mon_q[$];
  logic       mon_acks[$];
  int         n_start   = 0;
  int         n_stop    = 0;

  initial slave_low = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      slave_low = 1'b0;
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
    end else begin
      if (prev_scl && scl && prev_sda && !sda_w) begin
        n_start++;
        in_frame = 1'b1;
        bitpos   = 0;
        mon_q.delete();
        mon_acks.delete();
      end else if (prev_scl && scl && !prev_sda && sda_w) begin
        n_stop++;
        in_frame = 1'b0;
      end else if (in_frame && !prev_scl && scl) begin
        if (bitpos < 8) begin
          shreg = {shreg[6:0], sda_w};
          bitpos++;
        end else begin
          mon_q.push_back(shreg);
          mon_acks.push_back(sda_w);
          bitpos = 0;
        end
      end else if (in_frame && prev_scl && !scl) begin
        slave_low = (bitpos == 8) && !nack_plan[mon_q.size()];
      end
      prev_scl = scl;
      prev_sda = sda_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes sent and oEND latency from the NACK plan.
  function automatic int bytes_sent(input logic [2:0] plan);
    int n;
    n = 3;
`ifdef I2C_NACK_ABORT_EN
    for (int i = 2; i >= 0; i--) if (plan[i]) n = i + 1;
`endif
    return n;
  endfunction

  function automatic int exp_latency(input logic [2:0] plan);
    return (4 + bytes_sent(plan) * 9 * 4 + 4) * Q + 1;
  endfunction

  // Called #1 after the acceptance edge; counts edges until oEND.
  task automatic await_end(input string tag, input int exp_lat, input bit poke);
    int lat;
    int drops;
    lat   = 0;
    drops = 0;
    while (!oend && lat < 4000) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) drops++;
      if (poke && lat == 20) begin go = 1'b1; data = 24'($urandom); end
      if (poke && lat == 30) go = 1'b0;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_held"}, drops, 0);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] d, input logic [2:0] plan,
                             input int s0, input int t0);
    int   n;
    logic exp_ack;
    n = bytes_sent(plan);
    exp_ack = 1'b0;
    for (int i = 0; i < n; i++) exp_ack |= plan[i];
    check({tag, "_oack"}, oack, exp_ack);
    check({tag, "_busy_in_end"}, busy, 1);
    check({tag, "_nbytes"}, mon_q.size(), n);
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      check({tag, "_byte"}, mon_q[i], (d >> (16 - 8 * i)) & 24'hff);
      check({tag, "_ackbit"}, mon_acks[i], plan[i]);
    end
    check({tag, "_starts"}, n_start - s0, 1);
    check({tag, "_stops"}, n_stop - t0, 1);
  endtask

  task automatic single_frame(input string tag, input logic [23:0] d, input logic [2:0] plan);
    int s0;
    int t0;
    @(negedge clk);
    nack_plan = plan;
    s0 = n_start;
    t0 = n_stop;
    go   = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    go   = 1'b0;
    data = 24'($urandom);
    await_end(tag, exp_latency(plan), 1'b1);
    check_frame(tag, d, plan, s0, t0);
    @(posedge clk);
    #1;
    check({tag, "_end_pulse"}, oend, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_bus"}, {scl, sda_w}, 2'b11);
  endtask

  initial begin
    logic [23:0] d1;
    logic [23:0] d2;
    logic [23:0] rd;
    logic [2:0]  rp;
    int          s0;
    int          t0;
    int          guard;

    rst  = 1'b1;
    go   = 1'b0;
    data = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_scl", scl, 1);
    check("reset_sda", sda_w, 1);
    check("reset_busy", busy, 0);
    check("reset_end", oend, 0);
    check("reset_ack", oack, 0);
    @(negedge clk);
    rst = 1'b0;

    single_frame("basic", 24'h34_1201, 3'b000);
    single_frame("nack_b2", 24'h34_5A3C, 3'b010);
    single_frame("nack_b1", 24'h35_0F0F, 3'b001);
    single_frame("nack_b3", 24'h34_FF00, 3'b100);

    for (int k = 0; k < 6; k++) begin
      rd = 24'($urandom);
      rp = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      single_frame("random", rd, rp);
    end

    // Back-to-back with iGO held high across oEND.
    d1 = 24'h34_0801;
    d2 = 24'h34_0C00;
    @(negedge clk);
    nack_plan = 3'b000;
    s0 = n_start;
    t0 = n_stop;
    go   = 1'b1;
    data = d1;
    @(posedge clk);
    #1;
    data = d2;
    await_end("b2b_first", exp_latency(3'b000), 1'b0);
    check_frame("b2b_first", d1, 3'b000, s0, t0);
    s0 = n_start;
    t0 = n_stop;
    @(posedge clk);
    #1;
    check("b2b_gap_busy", busy, 0);
    check("b2b_gap_end", oend, 0);
    @(posedge clk);
    #1;
    check("b2b_rebusy", busy, 1);
    go = 1'b0;
    await_end("b2b_second", exp_latency(3'b000), 1'b0);
    check_frame("b2b_second", d2, 3'b000, s0, t0);
    @(posedge clk);
    #1;
    check("b2b_done_busy", busy, 0);

    // Reset during bit 5 of byte 2.
    @(negedge clk);
    nack_plan = 3'b000;
    go   = 1'b1;
    data = 24'h34_0000;
    @(posedge clk);
    #1;
    go = 1'b0;
    guard = 0;
    while (!(mon_q.size() == 1 && bitpos == 5) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("rst_reach_bit5", guard < 2000, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_scl", scl, 1);
    check("rst_mid_sda", sda_w, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_end", oend, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    single_frame("after_rst", 24'h34_1E00, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
